mem_slot_arbiter: RTL and testbench

- Time-slot arbiter and address decoder between the CPU, the video scanner and the shared memory bus.
- Successor to the fixed two-slot CPU/video multiplexer.
- Generalised in slot count, address/data width, read latency and region map; adds an I/O window, RAM write strobe, ROM write protection and per-requester data-ready strobes.
- Sits between the CPU core, video generator, RAM, ROM and I/O decode on the mem_phi domain.

---
 rtl/mem_slot_arbiter_pkg.sv | 28 ++
 rtl/mem_slot_arbiter_if.sv | 39 +++
 rtl/mem_slot_arbiter_region_decode.sv | 26 ++
 rtl/mem_slot_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_slot_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_slot_arbiter_pkg.sv
// Shared memory-map types for the slot arbiter and the blocks that reuse its decoder.
// Holds the region/requester enums, the read-tag struct and the default map constants.
package mem_map_pkg;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_ROM = 2'd1,
        REG_IO  = 2'd2
    } region_t;

    typedef enum logic {
        REQ_VID = 1'b0,
        REQ_CPU = 1'b1
    } req_t;

    typedef struct packed {
        logic    valid;
        req_t    req;
        region_t region;
    } tag_t;

    localparam logic [15:0] DEF_ROM_BASE = 16'hB000;
    localparam logic [15:0] DEF_IO_BASE  = 16'hC000;
    localparam int          DEF_IO_SIZE  = 256;

    localparam tag_t TAG_NONE = '{valid: 1'b0, req: REQ_VID, region: REG_RAM};

endpackage

// File: rtl/mem_slot_arbiter_if.sv
// Bundle of the CPU, video and shared-memory signals around the slot arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface mem_slot_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_adr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_dbo;
    logic [ADDR_W-1:0] vid_adr;
    logic              vid_en;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_dbo;
    logic              ram_we;
    logic              io_we;
    logic              io_cs;
    logic [DATA_W-1:0] ram_dbo;
    logic [DATA_W-1:0] rom_dbo;
    logic [DATA_W-1:0] io_dbo;
    logic [DATA_W-1:0] cpu_dbi;
    logic              cpu_rdy;
    logic [DATA_W-1:0] vid_dbi;
    logic              vid_rdy;
    logic              slot_cpu;
    logic              rom_wr_err;

    modport master (
        output cpu_adr, cpu_we, cpu_dbo, vid_adr, vid_en, ram_dbo, rom_dbo, io_dbo,
        input  mem_adr, mem_dbo, ram_we, io_we, io_cs, cpu_dbi, cpu_rdy,
               vid_dbi, vid_rdy, slot_cpu, rom_wr_err
    );

    modport slave (
        input  cpu_adr, cpu_we, cpu_dbo, vid_adr, vid_en, ram_dbo, rom_dbo, io_dbo,
        output mem_adr, mem_dbo, ram_we, io_we, io_cs, cpu_dbi, cpu_rdy,
               vid_dbi, vid_rdy, slot_cpu, rom_wr_err
    );

endinterface

// File: rtl/mem_slot_arbiter_region_decode.sv
// Combinational address-to-region decoder; the I/O window takes priority over ROM.
// The window end is computed one bit wider so a window at the top of memory cannot wrap.
module region_decode
    import mem_map_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(DEF_ROM_BASE),
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(DEF_IO_BASE),
    parameter int              IO_SIZE  = DEF_IO_SIZE
) (
    input  logic [ADDR_W-1:0] adr,
    output region_t           region
);

    localparam logic [ADDR_W:0] IO_END = {1'b0, IO_BASE} + (ADDR_W+1)'(IO_SIZE);

    always_comb begin
        region = REG_RAM;
        if ((adr >= IO_BASE) && ({1'b0, adr} < IO_END)) begin
            region = REG_IO;
        end else if (adr >= ROM_BASE) begin
            region = REG_ROM;
        end
    end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slot arbiter between video (slot 0) and CPU (slot 1) on the shared memory bus.
// Read tags travel down a short pipeline so returning data is steered to the right requester.
module mem_slot_arbiter
    import mem_map_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 8,
    parameter int              SLOTS    = 2,
    parameter int              RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(DEF_ROM_BASE),
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(DEF_IO_BASE),
    parameter int              IO_SIZE  = DEF_IO_SIZE
) (
    input  logic           mem_phi,
    input  logic           reset,
    mem_slot_arbiter_if.slave bus
);

    localparam int              PH_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOTS - 1);

    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_dbo_q, mem_dbo_d;
    logic              ram_we_q, ram_we_d;
    logic              io_we_q, io_we_d;
    logic              io_cs_q, io_cs_d;
    logic [DATA_W-1:0] cpu_dbi_q, cpu_dbi_d;
    logic [DATA_W-1:0] vid_dbi_q, vid_dbi_d;
    logic              cpu_rdy_q, cpu_rdy_d;
    logic              vid_rdy_q, vid_rdy_d;
    logic              slot_cpu_q, slot_cpu_d;
    logic              rom_wr_err_q, rom_wr_err_d;
    tag_t              tag_q [RD_LAT+1];
    tag_t              tag_d [RD_LAT+1];

    logic [ADDR_W-1:0] slot_adr;
    region_t           slot_region;
    tag_t              head_tag;
    logic [DATA_W-1:0] rd_data;

    assign slot_adr = (phase_q == PH_W'(0)) ? bus.vid_adr : bus.cpu_adr;
    assign head_tag = tag_q[RD_LAT];

    region_decode #(
        .ADDR_W   (ADDR_W),
        .ROM_BASE (ROM_BASE),
        .IO_BASE  (IO_BASE),
        .IO_SIZE  (IO_SIZE)
    ) u_region_decode (
        .adr    (slot_adr),
        .region (slot_region)
    );

    always_comb begin
        case (head_tag.region)
            REG_ROM: rd_data = bus.rom_dbo;
            REG_IO:  rd_data = bus.io_dbo;
            default: rd_data = bus.ram_dbo;
        endcase
    end

    always_comb begin
        phase_d      = (phase_q == PH_LAST) ? PH_W'(0) : phase_q + PH_W'(1);
        mem_adr_d    = mem_adr_q;
        mem_dbo_d    = mem_dbo_q;
        slot_cpu_d   = slot_cpu_q;
        cpu_dbi_d    = cpu_dbi_q;
        vid_dbi_d    = vid_dbi_q;
        ram_we_d     = 1'b0;
        io_we_d      = 1'b0;
        io_cs_d      = 1'b0;
        rom_wr_err_d = 1'b0;
        cpu_rdy_d    = 1'b0;
        vid_rdy_d    = 1'b0;
        tag_d[0]     = TAG_NONE;
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (phase_q == PH_W'(0)) begin
            if (bus.vid_en) begin
                mem_adr_d  = bus.vid_adr;
                slot_cpu_d = 1'b0;
                tag_d[0]   = '{valid: 1'b1, req: REQ_VID, region: slot_region};
            end
        end else if (phase_q == PH_W'(1)) begin
            mem_adr_d  = bus.cpu_adr;
            mem_dbo_d  = bus.cpu_dbo;
            slot_cpu_d = 1'b1;
            io_cs_d    = (slot_region == REG_IO);
            if (bus.cpu_we) begin
                ram_we_d     = (slot_region == REG_RAM);
                io_we_d      = (slot_region == REG_IO);
                rom_wr_err_d = (slot_region == REG_ROM);
            end else begin
                tag_d[0] = '{valid: 1'b1, req: REQ_CPU, region: slot_region};
            end
        end

        // The tag at the head marks the cycle its read data is on the return buses.
        if (head_tag.valid) begin
            if (head_tag.req == REQ_CPU) begin
                cpu_dbi_d = rd_data;
                cpu_rdy_d = 1'b1;
            end else begin
                vid_dbi_d = rd_data;
                vid_rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mem_phi) begin
        if (reset) begin
            phase_q      <= '0;
            mem_adr_q    <= '0;
            mem_dbo_q    <= '0;
            ram_we_q     <= 1'b0;
            io_we_q      <= 1'b0;
            io_cs_q      <= 1'b0;
            cpu_dbi_q    <= '0;
            vid_dbi_q    <= '0;
            cpu_rdy_q    <= 1'b0;
            vid_rdy_q    <= 1'b0;
            slot_cpu_q   <= 1'b0;
            rom_wr_err_q <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            phase_q      <= phase_d;
            mem_adr_q    <= mem_adr_d;
            mem_dbo_q    <= mem_dbo_d;
            ram_we_q     <= ram_we_d;
            io_we_q      <= io_we_d;
            io_cs_q      <= io_cs_d;
            cpu_dbi_q    <= cpu_dbi_d;
            vid_dbi_q    <= vid_dbi_d;
            cpu_rdy_q    <= cpu_rdy_d;
            vid_rdy_q    <= vid_rdy_d;
            slot_cpu_q   <= slot_cpu_d;
            rom_wr_err_q <= rom_wr_err_d;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.mem_adr    = mem_adr_q;
    assign bus.mem_dbo    = mem_dbo_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.io_we      = io_we_q;
    assign bus.io_cs      = io_cs_q;
    assign bus.cpu_dbi    = cpu_dbi_q;
    assign bus.vid_dbi    = vid_dbi_q;
    assign bus.cpu_rdy    = cpu_rdy_q;
    assign bus.vid_rdy    = vid_rdy_q;
    assign bus.slot_cpu   = slot_cpu_q;
    assign bus.rom_wr_err = rom_wr_err_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter: a two-slot/RD_LAT=1 instance and a four-slot/RD_LAT=2 instance.
// Memories are simple latency pipes returning adr[7:0]; ROM and I/O return fixed bytes.
module tb_mem_slot_arbiter;

    logic mem_phi;
    logic rst_a;
    logic rst_b;

    int vectorCount = 0;
    int missCount   = 0;

    mem_slot_arbiter_if #(.ADDR_W(16), .DATA_W(8)) ifa ();
    mem_slot_arbiter_if #(.ADDR_W(16), .DATA_W(8)) ifb ();

    mem_slot_arbiter #(.SLOTS(2), .RD_LAT(1)) dut_a (
        .mem_phi (mem_phi),
        .reset   (rst_a),
        .bus     (ifa)
    );

    mem_slot_arbiter #(.SLOTS(4), .RD_LAT(2)) dut_b (
        .mem_phi (mem_phi),
        .reset   (rst_b),
        .bus     (ifb)
    );

    initial mem_phi = 1'b0;
    always #5 mem_phi = ~mem_phi;

    // Memory models: one-stage RAM for instance A, two-stage RAM for instance B.
    logic [7:0] ram_a_q;
    logic [7:0] ram_b1_q;
    logic [7:0] ram_b2_q;
    always @(posedge mem_phi) begin
        ram_a_q  <= ifa.mem_adr[7:0];
        ram_b1_q <= ifb.mem_adr[7:0];
        ram_b2_q <= ram_b1_q;
    end
    assign ifa.ram_dbo = ram_a_q;
    assign ifa.rom_dbo = 8'hEA;
    assign ifa.io_dbo  = 8'h3C;
    assign ifb.ram_dbo = ram_b2_q;
    assign ifb.rom_dbo = 8'h96;
    assign ifb.io_dbo  = 8'h69;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge mem_phi);
        @(negedge mem_phi);
    endtask

    task automatic applyStimulus(input logic vid_en, input logic [15:0] vid_adr,
                                 input logic [15:0] cpu_adr, input logic cpu_we,
                                 input logic [7:0] cpu_dbo);
        ifa.vid_en  = vid_en;
        ifa.vid_adr = vid_adr;
        ifa.cpu_adr = cpu_adr;
        ifa.cpu_we  = cpu_we;
        ifa.cpu_dbo = cpu_dbo;
    endtask

    // Called at a negedge where the next edge is the CPU slot of instance A.
    task automatic cpuRead(input logic [15:0] adr, input logic [7:0] exp_data, input logic exp_io_cs);
        ifa.cpu_adr = adr;
        ifa.cpu_we  = 1'b0;
        tick();
        checkOutput("rd_mem_adr", ifa.mem_adr, adr);
        checkOutput("rd_slot_cpu", ifa.slot_cpu, 1);
        checkOutput("rd_io_cs", ifa.io_cs, exp_io_cs);
        checkOutput("rd_ram_we", ifa.ram_we, 0);
        checkOutput("rd_io_we", ifa.io_we, 0);
        tick();
        checkOutput("rd_rdy_early", ifa.cpu_rdy, 0);
        checkOutput("rd_io_cs_drop", ifa.io_cs, 0);
        tick();
        checkOutput("rd_rdy", ifa.cpu_rdy, 1);
        checkOutput("rd_dbi", ifa.cpu_dbi, exp_data);
        checkOutput("rd_vid_rdy_excl", ifa.vid_rdy, 0);
        tick();
        checkOutput("rd_rdy_pulse", ifa.cpu_rdy, 0);
        checkOutput("rd_dbi_hold", ifa.cpu_dbi, exp_data);
    endtask

    task automatic cpuWrite(input logic [15:0] adr, input logic [7:0] dbo,
                            input logic exp_ram_we, input logic exp_io_we, input logic exp_err);
        ifa.cpu_adr = adr;
        ifa.cpu_we  = 1'b1;
        ifa.cpu_dbo = dbo;
        tick();
        checkOutput("wr_mem_adr", ifa.mem_adr, adr);
        checkOutput("wr_mem_dbo", ifa.mem_dbo, dbo);
        checkOutput("wr_ram_we", ifa.ram_we, exp_ram_we);
        checkOutput("wr_io_we", ifa.io_we, exp_io_we);
        checkOutput("wr_io_cs", ifa.io_cs, exp_io_we);
        checkOutput("wr_rom_err", ifa.rom_wr_err, exp_err);
        ifa.cpu_we = 1'b0;
        tick();
        checkOutput("wr_strobe_off", {ifa.ram_we, ifa.io_we, ifa.io_cs, ifa.rom_wr_err}, 0);
        tick();
        checkOutput("wr_no_rdy", ifa.cpu_rdy, 0);
        tick();
    endtask

    logic [15:0] rd_adr  [8] = '{16'h0255, 16'hF000, 16'hC010, 16'hAFFF,
                                 16'hFFFF, 16'hC0FF, 16'hC100, 16'hBFFF};
    logic [7:0]  rd_data [8] = '{8'h55, 8'hEA, 8'h3C, 8'hFF, 8'hEA, 8'h3C, 8'hEA, 8'hEA};
    logic        rd_io   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic [15:0] b_adr  [3] = '{16'h0311, 16'hF123, 16'hC005};
    logic [7:0]  b_data [3] = '{8'h11, 8'h96, 8'h69};
    logic        b_io   [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        applyStimulus(1'b1, 16'h0400, 16'h0200, 1'b0, 8'h00);
        ifb.vid_en  = 1'b0;
        ifb.vid_adr = 16'h0777;
        ifb.cpu_adr = 16'h0000;
        ifb.cpu_we  = 1'b0;
        ifb.cpu_dbo = 8'h00;
        repeat (2) @(posedge mem_phi);
        @(negedge mem_phi);

        checkOutput("rst_mem_adr", ifa.mem_adr, 0);
        checkOutput("rst_strobes", {ifa.ram_we, ifa.io_we, ifa.io_cs, ifa.rom_wr_err}, 0);
        checkOutput("rst_rdy", {ifa.cpu_rdy, ifa.vid_rdy, ifa.slot_cpu}, 0);
        checkOutput("rst_dbi", {ifa.cpu_dbi, ifa.vid_dbi, ifa.mem_dbo}, 0);
        checkOutput("rst_b_mem_adr", ifb.mem_adr, 0);

        // Alternating video/CPU slots on instance A.
        rst_a = 1'b0;
        tick();
        checkOutput("alt_vid_adr", ifa.mem_adr, 16'h0400);
        checkOutput("alt_vid_slot", ifa.slot_cpu, 0);
        tick();
        checkOutput("alt_cpu_adr", ifa.mem_adr, 16'h0200);
        checkOutput("alt_cpu_slot", ifa.slot_cpu, 1);
        checkOutput("alt_no_rdy", {ifa.cpu_rdy, ifa.vid_rdy}, 0);
        tick();
        checkOutput("alt_vid_rdy", ifa.vid_rdy, 1);
        checkOutput("alt_vid_dbi", ifa.vid_dbi, 8'h00);
        checkOutput("alt_cpu_rdy_low", ifa.cpu_rdy, 0);
        checkOutput("alt_vid_adr2", ifa.mem_adr, 16'h0400);
        tick();
        checkOutput("alt_cpu_rdy", ifa.cpu_rdy, 1);
        checkOutput("alt_cpu_dbi", ifa.cpu_dbi, 8'h00);
        checkOutput("alt_vid_rdy_low", ifa.vid_rdy, 0);

        ifa.vid_adr = 16'h0433;
        tick();

        for (int i = 0; i < 8; i++) begin
            cpuRead(rd_adr[i], rd_data[i], rd_io[i]);
            if (i == 0) begin
                checkOutput("vid_rdy_new", ifa.vid_rdy, 1);
                checkOutput("vid_dbi_new", ifa.vid_dbi, 8'h33);
            end
        end

        cpuWrite(16'hC010, 8'h5A, 1'b0, 1'b1, 1'b0);
        cpuWrite(16'hB000, 8'hA5, 1'b0, 1'b0, 1'b1);
        cpuWrite(16'hAFFF, 8'hC3, 1'b1, 1'b0, 1'b0);
        cpuWrite(16'hFFFF, 8'h81, 1'b0, 1'b0, 1'b1);

        // Reset one cycle after a CPU read slot discards that read.
        ifa.cpu_adr = 16'h0277;
        ifa.cpu_we  = 1'b0;
        tick();
        checkOutput("pre_rst_adr", ifa.mem_adr, 16'h0277);
        rst_a = 1'b1;
        tick();
        checkOutput("mid_rst_adr", ifa.mem_adr, 0);
        checkOutput("mid_rst_dbo", ifa.mem_dbo, 0);
        checkOutput("mid_rst_dbi", {ifa.cpu_dbi, ifa.vid_dbi}, 0);
        checkOutput("mid_rst_flags", {ifa.cpu_rdy, ifa.vid_rdy, ifa.slot_cpu, ifa.ram_we,
                                      ifa.io_we, ifa.io_cs, ifa.rom_wr_err}, 0);
        rst_a = 1'b0;
        tick();
        checkOutput("post_rst_vid_adr", ifa.mem_adr, 16'h0433);
        checkOutput("post_rst_slot", ifa.slot_cpu, 0);
        checkOutput("post_rst_no_rdy", ifa.cpu_rdy, 0);
        tick();
        checkOutput("post_rst_cpu_adr", ifa.mem_adr, 16'h0277);
        checkOutput("post_rst_quiet", {ifa.cpu_rdy, ifa.vid_rdy}, 0);
        tick();
        checkOutput("post_rst_vid_rdy", ifa.vid_rdy, 1);
        checkOutput("post_rst_vid_dbi", ifa.vid_dbi, 8'h33);
        tick();
        checkOutput("post_rst_cpu_rdy", ifa.cpu_rdy, 1);
        checkOutput("post_rst_cpu_dbi", ifa.cpu_dbi, 8'h77);

        // Four-slot instance with video disabled: one CPU read per frame.
        rst_b = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k % 4 == 2) begin
                ifb.cpu_adr = b_adr[(k - 2) / 4];
            end
            tick();
            checkOutput("b_mem_adr", ifb.mem_adr, (k == 1) ? 16'h0000 : b_adr[(k - 2) / 4]);
            checkOutput("b_cpu_rdy", ifb.cpu_rdy, (k % 4 == 1) && (k >= 5));
            checkOutput("b_vid_rdy", ifb.vid_rdy, 0);
            checkOutput("b_io_cs", ifb.io_cs, (k % 4 == 2) && b_io[(k - 2) / 4]);
            checkOutput("b_ram_we", ifb.ram_we, 0);
            if (k >= 5) begin
                checkOutput("b_cpu_dbi", ifb.cpu_dbi, b_data[(k - 5) / 4]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
